spi_rx_fifo: RTL and testbench

- Parametrised receive FIFO for the SPI SD path.
- Takes bytes announced by a level strobe from the SPI shifter and detects the strobe's rising edge, so one strobe pulse pushes exactly one entry.
- Stores entries in a DEPTH-entry circular buffer; the SD controller drains it with a pop handshake.
- Adds occupancy count, full/empty flags, sticky overflow/underflow and synchronous flush.

---
 rtl/spi_rx_fifo.sv | 95 +++++++++
 tb/tb_spi_rx_fifo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_fifo.sv
// Receive FIFO for the SPI SD path: rising-edge-detected pushes, circular buffer, sticky error flags.
// Define SPI_RX_FIFO_FWFT_EN for first-word-fall-through reads (default: registered 1-cycle pop).
module spi_rx_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_strobe,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic              s_stb, prev_stb, push_q;
  logic [DATA_W-1:0] s_dat, push_dat;
  logic              do_pop, do_push;
  logic [CNT_W-1:0]  count_nxt;

  // A pop accepted in the same cycle frees the slot a full-FIFO push needs.
  always_comb begin
    do_pop    = rst & ~clr & rd_req & ~empty;
    do_push   = rst & ~clr & push_q & (~full | do_pop);
    count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s_stb    <= 1'b0;
      s_dat    <= '0;
      prev_stb <= 1'b0;
      push_q   <= 1'b0;
      push_dat <= '0;
    end else begin
      s_stb    <= wr_strobe;
      s_dat    <= wr_data;
      prev_stb <= s_stb;
      push_q   <= clr ? 1'b0 : (s_stb & ~prev_stb);
      push_dat <= s_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CNT_W'(DEPTH));
      if (push_q & full & ~do_pop) overflow  <= 1'b1;
      if (rd_req & empty)          underflow <= 1'b1;
    end
  end

`ifdef SPI_RX_FIFO_FWFT_EN
  always_comb begin
    rd_valid = ~empty;
    rd_data  = mem[rptr];
  end
`else
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= do_pop;
      if (do_pop) rd_data <= mem[rptr];
    end
  end
`endif

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Self-checking bench for spi_rx_fifo (default registered-pop build): queue model plus directed and random stimulus.
module tb_spi_rx_fifo;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          wr_strobe = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_req = 1'b0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [4:0]    count;
  logic          empty, full, overflow, underflow;

  spi_rx_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_strobe(wr_strobe), .wr_data(wr_data),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a push is a low->high transition in the strobe samples,
  // landing two edges after the high sample unless a clr intervened.
  logic [DW-1:0] q[$];
  bit            m_ov, m_un, m_rv, started;
  logic [DW-1:0] m_rd;
  bit            h0, h1, h2, kill;
  logic [DW-1:0] d0, d1;
  bit            m_push, m_pop;
  int            m_n;

  always @(posedge clk) begin
    if (!rst) begin
      q.delete();
      m_ov = 0; m_un = 0; m_rv = 0; m_rd = '0;
      h0 = 0; h1 = 0; h2 = 0; kill = 0; d0 = '0; d1 = '0;
      started = 1;
    end else begin
      m_push = h1 && !h2 && !kill;
      m_n = q.size();
      if (clr) begin
        q.delete();
        m_ov = 0; m_un = 0; m_rv = 0;
      end else begin
        m_pop = rd_req && (m_n > 0);
        m_rv = m_pop;
        if (rd_req && m_n == 0) m_un = 1;
        if (m_pop) m_rd = q.pop_front();
        if (m_push) begin
          if (q.size() < DEPTH) q.push_back(d1);
          else m_ov = 1;
        end
      end
      kill = clr;
      h2 = h1; h1 = h0; h0 = wr_strobe;
      d1 = d0; d0 = wr_data;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("count", int'(count), q.size());
      chk("empty", int'(empty), int'(q.size() == 0));
      chk("full", int'(full), int'(q.size() == DEPTH));
      chk("overflow", int'(overflow), int'(m_ov));
      chk("underflow", int'(underflow), int'(m_un));
      chk("rd_valid", int'(rd_valid), int'(m_rv));
      chk("rd_data", int'(rd_data), int'(m_rd));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [DW-1:0] d);
    wr_strobe = 1'b1; wr_data = d;
    cyc(1);
    wr_strobe = 1'b0;
    cyc(1);
  endtask

  task automatic do_clr();
    clr = 1'b1; cyc(1); clr = 1'b0;
  endtask

  initial begin
    // Reset then single held strobe
    rst = 1'b0; cyc(2); rst = 1'b1;
    chk("lit_reset_empty", int'(empty), 1);
    wr_strobe = 1'b1; wr_data = 8'hA5;
    cyc(1); chk("lit_e0_count", int'(count), 0);
    cyc(1); chk("lit_e1_count", int'(count), 0);
    cyc(1); chk("lit_e2_count", int'(count), 1);
    cyc(2); chk("lit_held_count", int'(count), 1);
    wr_strobe = 1'b0; cyc(2);
    rd_req = 1'b1; cyc(1); rd_req = 1'b0;
    chk("lit_pop_valid", int'(rd_valid), 1);
    chk("lit_pop_data", int'(rd_data), 8'hA5);
    chk("lit_pop_empty", int'(empty), 1);
    cyc(1); chk("lit_valid_drop", int'(rd_valid), 0);

    // Fill and overflow
    for (int i = 0; i < 17; i++) pulse(8'(i));
    cyc(2);
    chk("lit_full", int'(full), 1);
    chk("lit_overflow", int'(overflow), 1);
    rd_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      chk("lit_fill_order", int'(rd_data), i);
    end
    rd_req = 1'b0; cyc(1);
    chk("lit_drained", int'(empty), 1);
    do_clr();

    // Wrap-around
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) pulse(8'(8'h30 + r * 10 + i));
      cyc(2);
      chk("lit_wrap_count", int'(count), 10);
      rd_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
        cyc(1);
        chk("lit_wrap_order", int'(rd_data), 8'h30 + r * 10 + i);
      end
      rd_req = 1'b0; cyc(1);
    end
    chk("lit_wrap_flags", int'({overflow, underflow}), 0);

    // Full plus simultaneous push and pop
    for (int i = 0; i < 16; i++) pulse(8'(8'h50 + i));
    cyc(2);
    wr_strobe = 1'b1; wr_data = 8'hEE; cyc(1);
    wr_strobe = 1'b0; cyc(1);
    rd_req = 1'b1; cyc(1); rd_req = 1'b0;
    chk("lit_fullpp_count", int'(count), 16);
    chk("lit_fullpp_ovf", int'(overflow), 0);
    do_clr();

    // Empty plus simultaneous push and pop
    wr_strobe = 1'b1; wr_data = 8'h77; cyc(1);
    wr_strobe = 1'b0; cyc(1);
    rd_req = 1'b1; cyc(1); rd_req = 1'b0;
    chk("lit_emptypp_unf", int'(underflow), 1);
    chk("lit_emptypp_count", int'(count), 1);
    rd_req = 1'b1; cyc(1); rd_req = 1'b0;
    chk("lit_emptypp_data", int'(rd_data), 8'h77);
    do_clr();

    // Flush with a push pending
    pulse(8'h11); pulse(8'h22);
    wr_strobe = 1'b1; wr_data = 8'h33; cyc(2);
    chk("lit_preflush_count", int'(count), 2);
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("lit_flush_count", int'(count), 0);
    chk("lit_flush_empty", int'(empty), 1);
    cyc(4);
    chk("lit_flush_noretrig", int'(count), 0);
    wr_strobe = 1'b0; cyc(2);

    // Reset mid-operation
    for (int i = 0; i < 7; i++) pulse(8'(i + 1));
    cyc(2);
    chk("lit_pre_rst_count", int'(count), 7);
    rst = 1'b0; cyc(1); rst = 1'b1;
    chk("lit_rst_count", int'(count), 0);
    chk("lit_rst_empty", int'(empty), 1);
    chk("lit_rst_rd_data", int'(rd_data), 0);
    rd_req = 1'b1; cyc(1); rd_req = 1'b0;
    chk("lit_rst_unf", int'(underflow), 1);
    chk("lit_rst_valid", int'(rd_valid), 0);

    // Randomised traffic with varying pop pressure
    for (int seg = 0; seg < 4; seg++) begin
      int rd_pct;
      rd_pct = (seg == 0) ? 1 : (seg == 1) ? 6 : (seg == 2) ? 2 : 4;
      for (int i = 0; i < 800; i++) begin
        rst       = ($urandom_range(0, 299) != 0);
        clr       = ($urandom_range(0, 79) == 0);
        wr_strobe = 1'($urandom_range(0, 1));
        wr_data   = 8'($urandom);
        rd_req    = ($urandom_range(0, 9) < rd_pct);
        cyc(1);
      end
    end
    rst = 1'b1; clr = 1'b0; wr_strobe = 1'b0; rd_req = 1'b0;
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
